fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing and branch-control front end for the lab2 7-bit-address core. Decodes each 9-bit instruction word read from instruction memory at the current `pc` address. Drives the program counter's control inputs: reset/start load, halt, branch type, branch targets/offsets, and branch flag. Owns the run/halt state machine, the branch flag register and two performance counters.

## Interface
Parameters:
- `START_ADDR`, 7'd0, address loaded into the PC on every start.
- `CNT_W`, 16, width of the retired-instruction and taken-branch counters.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle go pulse; honoured only in IDLE or HALTED.
- `instr`  in  9  instruction at current `pc` (asynchronous-read instruction memory, valid same cycle).
- `pc`  in  7  current PC address (debug/compare only).
- `alu_zero`  in  1  ALU zero result, sampled by CMPF.
- `pc_reset`  out  1  to PC `reset`.
- `pc_start_addr`  out  7  to PC `startAddress`; constant `START_ADDR`.
- `halt`  out  1  to PC `halt`.
- `branch_type`  out  2  to PC `branchType`.
- `seven_bit_address`  out  7  JMP target.
- `three_bit_offset`  out  3  signed BNE3 offset.
- `six_bit_offset`  out  6  signed BNE6 offset.
- `flag`  out  1  registered branch flag, to PC `flag`.
- `running`  out  1  high in RUN.
- `done`  out  1  high in HALTED.
- `retired`  out  CNT_W  instructions retired since last start.
- `taken`  out  CNT_W  taken branches since last start.

## Operation
Decode (only in RUN; first match wins):
- `instr == 9'h1FF`: HALT.
- `instr[8:7] == 2'b10`: JMP. `branch_type=01`, `seven_bit_address=instr[6:0]`. Always taken.
- `instr[8:6] == 3'b110`: BNE6. `branch_type=11`, `six_bit_offset=instr[5:0]`. Taken iff `flag==0`.
- `instr[8:3] == 6'b111000`: BNE3. `branch_type=10`, `three_bit_offset=instr[2:0]`. Taken iff `flag==0`.
- `instr[8:3] == 6'b111001`: CMPF. `branch_type=00`; `flag <= alu_zero` at end of cycle.
- Anything else: sequential. `branch_type=00`.

Offset fields are passed through unmodified; the PC performs sign extension and 7-bit wrap-around addition.

Outside RUN, `branch_type=00`, and `seven_bit_address`, `three_bit_offset` and `six_bit_offset` are all 0.

FSM states: IDLE, LOAD, RUN, HALTED.
- IDLE: `halt=1`. `start` -> LOAD.
- LOAD: exactly one cycle with `pc_reset=1`, `halt=1`. Clears `retired`, `taken` and `flag`. Next state is RUN.
- RUN: `halt=0`, `running=1`. A HALT decode drives `halt=1` combinationally in the same cycle, so the PC holds on the HALT address; the next state is HALTED. `start` is ignored in RUN.
- HALTED: `halt=1`, `done=1`. `start` -> LOAD (restart).

Counters:
- `retired` increments once per RUN cycle whose instruction is not HALT.
- `taken` increments per RUN cycle with a taken JMP, BNE3 or BNE6.
- Both saturate at all-ones and never wrap.

Flag:
- BNE reads the current registered `flag`.
- CMPF followed immediately by BNE: the BNE sees the new value.

## Timing
- Reset values: state IDLE, `flag=0`, `retired=0`, `taken=0`, `pc_reset=0`, `halt=1`, `branch_type=00`, `running=0`, `done=0`.
- `reset` wins over `start` in the same cycle.
- `reset` mid-RUN returns to IDLE on the next edge. The PC is not reloaded until the next LOAD.
- Start latency: `start` high in cycle N -> `pc_reset=1` in N+1 -> PC = `START_ADDR` and first instruction decoded in N+2.
- Branch decode is combinational from `instr` and registered `flag`. The PC takes the new address on the edge ending that cycle, so no bubble is inserted.
- HALT to `done`: `done` is high the cycle after HALT is decoded.
- `start` asserted on the same cycle HALT is decoded is ignored.
- All outputs other than decode fields and `halt` are registered or derived from state only.

## Test plan
- Reset, then `start` pulse -> `pc_reset` high exactly one cycle. The next cycle has `running=1` and `pc=START_ADDR`; NOP stream gives `retired`=1,2,3 on successive cycles.
- `instr=9'b10_1010101` in RUN -> `branch_type=01`, `seven_bit_address=7'h55`, `taken`+1; the next `pc` is 7'h55.
- CMPF with `alu_zero=0`, then BNE3 `9'b111000_110` (offset -2) at pc=10 -> `flag=0`, `branch_type=10`, next pc=8, `taken`+1.
- CMPF with `alu_zero=1`, then BNE6 `9'b110_000101` at pc=20 -> not taken, next pc=21, `taken` unchanged, `retired`+1.
- HALT `9'h1FF` at pc=30 -> `halt=1` same cycle, `pc` stays 30, `done=1` next cycle, `retired` frozen. A later `start` reloads `START_ADDR` and clears the counters.
- `reset` asserted mid-RUN with `start` also high -> IDLE, `flag=0`, counters 0, `halt=1`, `pc_reset=0`. Counter saturation: force `CNT_W=2`; 5 NOPs -> `retired` stays 3.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Bus between the fetch controller and the program counter / instruction
// memory side: instruction and compare inputs, PC control outputs.
interface fetch_ctrl_if;
  logic [8:0] instr;
  logic [6:0] pc;
  logic       alu_zero;
  logic       pc_reset;
  logic [6:0] pc_start_addr;
  logic       halt;
  logic [1:0] branch_type;
  logic [6:0] seven_bit_address;
  logic [2:0] three_bit_offset;
  logic [5:0] six_bit_offset;
  logic       flag;

  // Controller side: consumes the fetched word, drives the PC controls.
  modport master (
    input  instr, pc, alu_zero,
    output pc_reset, pc_start_addr, halt, branch_type,
           seven_bit_address, three_bit_offset, six_bit_offset, flag
  );

  // PC / memory side: supplies the fetched word, follows the PC controls.
  modport slave (
    output instr, pc, alu_zero,
    input  pc_reset, pc_start_addr, halt, branch_type,
           seven_bit_address, three_bit_offset, six_bit_offset, flag
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Sequencing and branch-control front end for the lab2 7-bit-address core.
// Decodes the word at the current PC, steers the PC, owns the run/halt
// state machine, the branch flag and the retired/taken counters.
// The pc value on the bus is carried for observers; decode does not need it.
module fetch_ctrl #(
  parameter logic [6:0] START_ADDR = 7'd0,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  fetch_ctrl_if.master     bus,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] taken
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALTED} state_t;

  state_t           state_q, state_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] taken_q, taken_d;

  logic       isHalt, isJmp, isBne6, isBne3, isCmpf, brTaken;
  logic       haltNow;
  logic [1:0] branchType;
  logic [6:0] sevenAddr;
  logic [2:0] off3;
  logic [5:0] off6;

  // The opcode patterns are mutually exclusive, so no priority chain is needed.
  assign isHalt  = (bus.instr == 9'h1FF);
  assign isJmp   = (bus.instr[8:7] == 2'b10);
  assign isBne6  = (bus.instr[8:6] == 3'b110);
  assign isBne3  = (bus.instr[8:3] == 6'b111000);
  assign isCmpf  = (bus.instr[8:3] == 6'b111001);
  assign brTaken = isJmp || ((isBne6 || isBne3) && !flag_q);

  // Next state, counter/flag updates and the combinational decode fields.
  always_comb begin
    state_d    = state_q;
    flag_d     = flag_q;
    retired_d  = retired_q;
    taken_d    = taken_q;
    haltNow    = 1'b1;
    branchType = 2'b00;
    sevenAddr  = 7'd0;
    off3       = 3'd0;
    off6       = 6'd0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        state_d   = RUN;
        flag_d    = 1'b0;
        retired_d = '0;
        taken_d   = '0;
      end
      RUN: begin
        haltNow = 1'b0;
        if (isHalt) begin
          haltNow = 1'b1;
          state_d = HALTED;
        end else begin
          if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
          if (brTaken && (taken_q != '1)) taken_d = taken_q + CNT_W'(1);
          if (isJmp) begin
            branchType = 2'b01;
            sevenAddr  = bus.instr[6:0];
          end else if (isBne6) begin
            branchType = 2'b11;
            off6       = bus.instr[5:0];
          end else if (isBne3) begin
            branchType = 2'b10;
            off3       = bus.instr[2:0];
          end else if (isCmpf) begin
            flag_d = bus.alu_zero;
          end
        end
      end
      HALTED: begin
        if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, flag and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      flag_q    <= 1'b0;
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      state_q   <= state_d;
      flag_q    <= flag_d;
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign bus.pc_reset          = (state_q == LOAD);
  assign bus.pc_start_addr     = START_ADDR;
  assign bus.halt              = haltNow;
  assign bus.branch_type       = branchType;
  assign bus.seven_bit_address = sevenAddr;
  assign bus.three_bit_offset  = off3;
  assign bus.six_bit_offset    = off6;
  assign bus.flag              = flag_q;
  assign running               = (state_q == RUN);
  assign done                  = (state_q == HALTED);
  assign retired               = retired_q;
  assign taken                 = taken_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a bench-side PC follows the controller,
// a behavioural model predicts every cycle's outputs, and a monitor compares.
// A second instance with 2-bit counters shares the same stimulus.
module tb_fetch_ctrl;
  localparam logic [6:0] START = 7'h04;
  localparam int CW  = 16;
  localparam int CW2 = 2;
  localparam logic [8:0] NOP  = 9'h000;
  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [8:0] CMPF = 9'b111001_000;

  localparam int K_SEQ = 0, K_HALT = 1, K_JMP = 2, K_BNE6 = 3, K_BNE3 = 4, K_CMPF = 5;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HALTED = 3;

  typedef struct {
    logic [6:0]  pc;
    logic        pcReset;
    logic        halt;
    logic [1:0]  bt;
    logic [6:0]  a7;
    logic [2:0]  o3;
    logic [5:0]  o6;
    logic        flag;
    logic        running;
    logic        done;
    logic [15:0] retired;
    logic [15:0] taken;
    logic [1:0]  retired2;
    logic [1:0]  taken2;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start;
  logic running, done, running2, done2;
  logic [CW-1:0]  retired, taken;
  logic [CW2-1:0] retired2, taken2;
  logic [6:0] pcReg = 7'd0;

  int checks = 0;
  int failures = 0;
  exp_t q[$];

  int mPhase = P_IDLE;
  bit mFlag = 1'b0;
  int mRetired = 0;
  int mTaken = 0;
  int mPc = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if bus ();
  fetch_ctrl_if bus2 ();

  assign bus.pc        = pcReg;
  assign bus2.pc       = pcReg;
  assign bus2.instr    = bus.instr;
  assign bus2.alu_zero = bus.alu_zero;

  fetch_ctrl #(.START_ADDR(START), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.master),
    .running(running), .done(done), .retired(retired), .taken(taken)
  );

  fetch_ctrl #(.START_ADDR(START), .CNT_W(CW2)) dutSat (
    .clk(clk), .reset(reset), .start(start), .bus(bus2.master),
    .running(running2), .done(done2), .retired(retired2), .taken(taken2)
  );

  // Program counter as the core implements it, following the controller.
  always @(posedge clk) begin
    if (bus.pc_reset === 1'b1) pcReg <= bus.pc_start_addr;
    else if (bus.halt === 1'b0) begin
      case (bus.branch_type)
        2'b01: pcReg <= bus.seven_bit_address;
        2'b10: pcReg <= bus.flag ? pcReg + 7'd1 : pcReg + {{4{bus.three_bit_offset[2]}}, bus.three_bit_offset};
        2'b11: pcReg <= bus.flag ? pcReg + 7'd1 : pcReg + {bus.six_bit_offset[5], bus.six_bit_offset};
        default: pcReg <= pcReg + 7'd1;
      endcase
    end
  end

  function automatic int sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int classify(input logic [8:0] ins);
    if (ins == 9'h1FF) return K_HALT;
    if (ins[8:7] == 2'b10) return K_JMP;
    if (ins[8:6] == 3'b110) return K_BNE6;
    if (ins[8:3] == 6'b111000) return K_BNE3;
    if (ins[8:3] == 6'b111001) return K_CMPF;
    return K_SEQ;
  endfunction

  // Predict this cycle's outputs, queue them, then advance to the next cycle.
  task automatic modelStep(input bit rst, input bit st, input logic [8:0] ins,
                           input bit az, input bit push);
    exp_t e;
    int kind;
    bit isRun, tk;
    kind  = classify(ins);
    isRun = (mPhase == P_RUN);
    e.pc       = 7'(mPc);
    e.pcReset  = (mPhase == P_LOAD);
    e.running  = isRun;
    e.done     = (mPhase == P_HALTED);
    e.halt     = !isRun || (kind == K_HALT);
    e.bt = 2'd0; e.a7 = 7'd0; e.o3 = 3'd0; e.o6 = 6'd0;
    if (isRun) begin
      if (kind == K_JMP)  begin e.bt = 2'b01; e.a7 = ins[6:0]; end
      if (kind == K_BNE6) begin e.bt = 2'b11; e.o6 = ins[5:0]; end
      if (kind == K_BNE3) begin e.bt = 2'b10; e.o3 = ins[2:0]; end
    end
    e.flag     = mFlag;
    e.retired  = 16'(sat(mRetired, CW));
    e.taken    = 16'(sat(mTaken, CW));
    e.retired2 = 2'(sat(mRetired, CW2));
    e.taken2   = 2'(sat(mTaken, CW2));
    if (push) q.push_back(e);

    if (e.pcReset) mPc = int'(START);
    else if (!e.halt) begin
      case (kind)
        K_JMP:   mPc = int'(ins[6:0]);
        K_BNE3:  mPc = (mPc + (mFlag ? 1 : sext(int'(ins[2:0]), 3))) & 127;
        K_BNE6:  mPc = (mPc + (mFlag ? 1 : sext(int'(ins[5:0]), 6))) & 127;
        default: mPc = (mPc + 1) & 127;
      endcase
    end

    tk = isRun && ((kind == K_JMP) || (((kind == K_BNE3) || (kind == K_BNE6)) && !mFlag));
    if (rst) begin
      mPhase = P_IDLE; mFlag = 1'b0; mRetired = 0; mTaken = 0;
    end else begin
      case (mPhase)
        P_IDLE:   if (st) mPhase = P_LOAD;
        P_LOAD:   begin mPhase = P_RUN; mFlag = 1'b0; mRetired = 0; mTaken = 0; end
        P_RUN: begin
          if (kind == K_HALT) mPhase = P_HALTED;
          else begin
            mRetired++;
            if (tk) mTaken++;
            if (kind == K_CMPF) mFlag = az;
          end
        end
        default:  if (st) mPhase = P_LOAD;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit st, input logic [8:0] ins, input bit az);
    @(negedge clk);
    reset        = rst;
    start        = st;
    bus.instr    = ins;
    bus.alu_zero = az;
    modelStep(rst, st, ins, az, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] randInstr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return HALT;
    if (r <= 4) return {2'b10, 7'($urandom)};
    if (r <= 7) return {3'b110, 6'($urandom)};
    if (r <= 10) return {6'b111000, 3'($urandom)};
    if (r <= 13) return {6'b111001, 3'($urandom)};
    if (r == 18) return {4'b1111, 1'b0, 4'($urandom)};
    if (r == 19) return {5'b11101, 4'($urandom)};
    return {1'b0, 8'($urandom)};
  endfunction

  // Monitor: compare every queued expectation against the sampled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput("pc",            32'(bus.pc),                32'(e.pc));
        checkOutput("pc_reset",      32'(bus.pc_reset),          32'(e.pcReset));
        checkOutput("pc_start_addr", 32'(bus.pc_start_addr),     32'(START));
        checkOutput("halt",          32'(bus.halt),              32'(e.halt));
        checkOutput("branch_type",   32'(bus.branch_type),       32'(e.bt));
        checkOutput("seven_addr",    32'(bus.seven_bit_address), 32'(e.a7));
        checkOutput("three_off",     32'(bus.three_bit_offset),  32'(e.o3));
        checkOutput("six_off",       32'(bus.six_bit_offset),    32'(e.o6));
        checkOutput("flag",          32'(bus.flag),              32'(e.flag));
        checkOutput("running",       32'(running),               32'(e.running));
        checkOutput("done",          32'(done),                  32'(e.done));
        checkOutput("retired",       32'(retired),               32'(e.retired));
        checkOutput("taken",         32'(taken),                 32'(e.taken));
        checkOutput("retired_sat",   32'(retired2),              32'(e.retired2));
        checkOutput("taken_sat",     32'(taken2),                32'(e.taken2));
        checkOutput("running_sat",   32'(running2),              32'(e.running));
        checkOutput("done_sat",      32'(done2),                 32'(e.done));
        checkOutput("halt_sat",      32'(bus2.halt),             32'(e.halt));
        checkOutput("pc_reset_sat",  32'(bus2.pc_reset),         32'(e.pcReset));
        checkOutput("flag_sat",      32'(bus2.flag),             32'(e.flag));
      end
    end
  end

  // Directed scenarios first, then a randomized instruction stream.
  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.instr    = NOP;
    bus.alu_zero = 1'b0;
    modelStep(1'b1, 1'b0, NOP, 1'b0, 1'b0);

    applyStimulus(1, 0, NOP, 0);
    applyStimulus(0, 0, NOP, 0);
    applyStimulus(0, 1, NOP, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, NOP, 0);
    applyStimulus(0, 0, 9'b10_1010101, 0);
    applyStimulus(0, 0, NOP, 0);
    applyStimulus(0, 0, 9'b10_0001001, 0);
    applyStimulus(0, 0, CMPF, 0);
    applyStimulus(0, 0, 9'b111000_110, 0);
    applyStimulus(0, 0, NOP, 0);
    applyStimulus(0, 0, 9'b10_0010011, 0);
    applyStimulus(0, 0, CMPF, 1);
    applyStimulus(0, 0, 9'b110_000101, 0);
    applyStimulus(0, 0, NOP, 0);
    applyStimulus(0, 0, 9'b10_0011110, 0);
    applyStimulus(0, 1, HALT, 0);
    applyStimulus(0, 0, NOP, 0);
    applyStimulus(0, 0, NOP, 0);
    applyStimulus(0, 1, NOP, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, NOP, 0);
    applyStimulus(1, 1, NOP, 0);
    applyStimulus(0, 0, NOP, 0);
    applyStimulus(0, 0, NOP, 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                    randInstr(), 1'($urandom));
    end

    @(negedge clk);
    #5;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
